// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants, state encoding and symbol type for the Morse receiver
package morse_pkg;

    // Mark lengths above this many units are dashes.
    localparam int DOT_MAX_UNITS  = 1;
    // Space length that closes a character.
    localparam int CHAR_GAP_UNITS = 2;
    // Space length that closes a word.
    localparam int WORD_GAP_UNITS = 5;
    // Elements kept per character; sized to match the 6-bit symbol field.
    localparam int MAX_ELEMS      = 6;

    // Width of the saturating run-length counter.
    localparam int RUN_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        IN_CHAR,
        AFTER_CHAR
    } morse_state_t;

    typedef struct packed {
        logic [2:0] len;
        logic [5:0] bits;
        logic       err;
    } morse_sym_t;

    // A mark measured in units is a dash when it is longer than a dot.
    function automatic logic is_dash(input logic [RUN_W-1:0] units);
        return units > RUN_W'(DOT_MAX_UNITS);
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - input synchronizer, edge detect and unit-quantized run-length timer
//
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   pin_rx       : raw asynchronous Morse input (1 = mark)
//   rx_s         : synchronized input level
//   rise, fall   : one-cycle pulses in the first cycle rx_s shows the new level
//   tick         : one-cycle pulse at the end of every full unit within a run
//   run_units    : completed units in the current run, saturating at 7;
//                  on an edge cycle it still holds the length of the run just ended
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 2_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin_rx,
    output logic             rx_s,
    output logic             rise,
    output logic             fall,
    output logic             tick,
    output logic [RUN_W-1:0] run_units
);

    localparam int CW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0]    TERM    = CW'(UNIT_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_SAT = '1;

    logic          sync1;
    logic          rx_d;
    logic          rx_edge;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] cnt_eff;

    assign rise    = rx_s & ~rx_d;
    assign fall    = ~rx_s & rx_d;
    assign rx_edge = rise | fall;

    // The edge cycle is counted as cycle 0 of the new run, so a run of
    // D cycles produces exactly floor(D / UNIT_CYCLES) ticks before it ends.
    always_comb begin
        cnt_eff = rx_edge ? '0 : cyc_cnt;
        tick    = (cnt_eff == TERM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            rx_s      <= 1'b0;
            rx_d      <= 1'b0;
            cyc_cnt   <= '0;
            run_units <= '0;
        end else begin
            sync1 <= pin_rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;

            cyc_cnt <= tick ? '0 : cnt_eff + 1'b1;

            if (rx_edge) begin
                run_units <= '0;
            end else if (tick && run_units != RUN_SAT) begin
                run_units <= run_units + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_rx.sv
// rtl/morse_rx.sv - Morse receiver: classifies marks, assembles characters, one-deep output register
//
// Ports:
//   CLK, RST_N : clock and asynchronous active-low reset
//   PIN_RX     : asynchronous Morse input, high = mark
//   sym_valid  : character held in the output register
//   sym_ready  : consumer accepts the held character
//   sym_len    : element count of the held character (1..6)
//   sym_bits   : element i at bit i, 1 = dash, unused bits 0
//   sym_err    : character had more elements than fit; first six kept
//   word_gap   : one-cycle pulse when a word gap is seen
//   overflow   : sticky, a character completed while the register was full
module morse_rx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 2_000_000,
    parameter int MAX_ELEMS   = 6
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PIN_RX,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [2:0] sym_len,
    output logic [5:0] sym_bits,
    output logic       sym_err,
    output logic       word_gap,
    output logic       overflow
);

    localparam logic [2:0]       ELEM_FULL   = 3'(MAX_ELEMS);
    localparam logic [RUN_W-1:0] CHAR_BEFORE = RUN_W'(CHAR_GAP_UNITS - 1);
    localparam logic [RUN_W-1:0] WORD_BEFORE = RUN_W'(WORD_GAP_UNITS - 1);

    logic             rx_s;
    logic             rise;
    logic             fall;
    logic             tick;
    logic [RUN_W-1:0] run_units;

    // Classification happens on the falling edge alone; the rising edge
    // carries no information the FSM needs.
    logic unused_rise;
    assign unused_rise = rise;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .pin_rx   (PIN_RX),
        .rx_s     (rx_s),
        .rise     (rise),
        .fall     (fall),
        .tick     (tick),
        .run_units(run_units)
    );

    morse_state_t state;
    logic [2:0]   elem_cnt;
    logic [5:0]   elem_bits;
    logic         err_pend;
    morse_sym_t   hold_q;
    morse_sym_t   char_d;

    logic valid_mark;
    logic space_tick;
    logic can_load;

    always_comb begin
        char_d.len  = elem_cnt;
        char_d.bits = elem_bits;
        char_d.err  = err_pend;
    end

    // A mark too short to reach one unit is a glitch and leaves the
    // element buffer and state alone; the timer already restarted the
    // space measurement at the glitch edges.
    assign valid_mark = fall && (run_units != '0);
    assign space_tick = tick && !rx_s;
    // Loading is allowed when the register is empty or being drained now.
    assign can_load   = !sym_valid || sym_ready;

    assign sym_len  = hold_q.len;
    assign sym_bits = hold_q.bits;
    assign sym_err  = hold_q.err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            elem_cnt  <= '0;
            elem_bits <= '0;
            err_pend  <= 1'b0;
            hold_q    <= '0;
            sym_valid <= 1'b0;
            word_gap  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            word_gap <= 1'b0;

            if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end

            if (valid_mark) begin
                if (elem_cnt == ELEM_FULL) begin
                    err_pend <= 1'b1;
                end else begin
                    elem_bits[elem_cnt] <= is_dash(run_units);
                    elem_cnt            <= elem_cnt + 1'b1;
                end
                state <= IN_CHAR;
            end else if (space_tick) begin
                case (state)
                    IN_CHAR: begin
                        if (run_units == CHAR_BEFORE && elem_cnt != '0) begin
                            // A load here overrides the drain above, so a
                            // same-cycle accept keeps sym_valid high.
                            if (can_load) begin
                                hold_q    <= char_d;
                                sym_valid <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                            elem_cnt  <= '0;
                            elem_bits <= '0;
                            err_pend  <= 1'b0;
                            state     <= AFTER_CHAR;
                        end
                    end
                    AFTER_CHAR: begin
                        if (run_units == WORD_BEFORE) begin
                            word_gap <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_rx.sv
// tb/tb_morse_rx.sv - randomized and directed self-checking bench for morse_rx
module tb_morse_rx;

    localparam int U = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PIN_RX = 1'b0;
    logic       sym_ready = 1'b0;
    logic       sym_valid;
    logic [2:0] sym_len;
    logic [5:0] sym_bits;
    logic       sym_err;
    logic       word_gap;
    logic       overflow;

    morse_rx #(
        .UNIT_CYCLES(U)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PIN_RX   (PIN_RX),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_len  (sym_len),
        .sym_bits (sym_bits),
        .sym_err  (sym_err),
        .word_gap (word_gap),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [9:0] sym;
    } ev_t;

    int n_checks = 0;
    int n_pass   = 0;

    bit         pat[$];
    ev_t        rec[$];
    int         wg_rec[$];
    bit         vhist[$];
    logic [9:0] phist[$];
    ev_t        m_em[$];
    int         m_wg[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic add_run(input bit lvl, input int n);
        for (int i = 0; i < n; i++) pat.push_back(lvl);
    endtask

    task automatic add_bits(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h31) add_run(1'b1, U);
            else if (s[i] == 8'h30) add_run(1'b0, U);
        end
    endtask

    // Reference: split the pin waveform into runs and apply the Morse
    // timing rules to run lengths. Events appear 2 sync cycles after the
    // pin run starts plus the threshold length of the space.
    task automatic run_model();
        int n, i, j, d, u, mode, cnt, t;
        logic [5:0] bits;
        bit err, lvl;
        ev_t e;
        m_em.delete();
        m_wg.delete();
        n = pat.size();
        i = 0; mode = 0; cnt = 0; bits = '0; err = 1'b0;
        while (i < n) begin
            lvl = pat[i];
            j = i;
            while (j < n && pat[j] == lvl) j++;
            d = j - i;
            u = (d / U > 7) ? 7 : d / U;
            if (lvl) begin
                if (j < n && u > 0) begin
                    if (cnt < 6) begin
                        bits[cnt] = (u >= 2);
                        cnt++;
                    end else begin
                        err = 1'b1;
                    end
                    mode = 1;
                end
            end else begin
                if (mode == 1 && d >= 2 * U) begin
                    t = i + 2 + 2 * U;
                    if (t < n) begin
                        e.cyc = t;
                        e.sym = {3'(cnt), bits, err};
                        m_em.push_back(e);
                    end
                    cnt = 0; bits = '0; err = 1'b0; mode = 2;
                end
                if (mode == 2 && d >= 5 * U) begin
                    t = i + 2 + 5 * U;
                    if (t < n) m_wg.push_back(t);
                    mode = 0;
                end
            end
            i = j;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        PIN_RX = 1'b0;
        sym_ready = 1'b0;
        @(negedge CLK);
        check("reset_outs", {sym_valid, sym_len, sym_bits, sym_err, word_gap, overflow}, 32'd0);
        RST_N = 1'b1;
    endtask

    // Cycle k = k-th negedge after reset release; pat[k] is applied there.
    task automatic run_scen(input int ready_from);
        ev_t e;
        rec.delete(); wg_rec.delete(); vhist.delete(); phist.delete();
        do_reset();
        for (int k = 0; k < pat.size(); k++) begin
            @(negedge CLK);
            sym_ready = (k >= ready_from);
            if (sym_valid && sym_ready) begin
                e.cyc = k;
                e.sym = {sym_len, sym_bits, sym_err};
                rec.push_back(e);
            end
            if (word_gap) wg_rec.push_back(k);
            vhist.push_back(sym_valid);
            phist.push_back({sym_len, sym_bits, sym_err});
            PIN_RX = pat[k];
        end
    endtask

    task automatic compare_model(input string tag);
        int m;
        check({tag, "_nchar"}, rec.size(), m_em.size());
        m = (rec.size() < m_em.size()) ? rec.size() : m_em.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_cyc"}, rec[i].cyc, m_em[i].cyc);
            check({tag, "_sym"}, rec[i].sym, m_em[i].sym);
        end
        check({tag, "_nwg"}, wg_rec.size(), m_wg.size());
        m = (wg_rec.size() < m_wg.size()) ? wg_rec.size() : m_wg.size();
        for (int i = 0; i < m; i++) check({tag, "_wgcyc"}, wg_rec[i], m_wg[i]);
    endtask

    task automatic gen_random();
        int nch, ne, u;
        pat.delete();
        nch = $urandom_range(3, 6);
        for (int c = 0; c < nch; c++) begin
            ne = $urandom_range(1, 7);
            for (int e = 0; e < ne; e++) begin
                u = ($urandom_range(0, 1) == 1) ? 1 : $urandom_range(2, 8);
                add_run(1'b1, u * U + $urandom_range(0, U - 1));
                if (e < ne - 1) begin
                    if ($urandom_range(0, 3) == 0) begin
                        add_run(1'b0, 1);
                        add_run(1'b1, $urandom_range(1, U - 1));
                        add_run(1'b0, $urandom_range(1, U + 2));
                    end else begin
                        add_run(1'b0, U + $urandom_range(0, U - 1));
                    end
                end
            end
            add_run(1'b0, (($urandom_range(0, 2) == 0) ? 7 * U : 3 * U) + $urandom_range(0, U - 1));
        end
        add_run(1'b0, 8 * U);
    endtask

    initial begin
        int rf, bad;

        // SOS loopback
        pat.delete();
        add_bits("10101000_11101110111000_10101000");
        add_run(1'b0, 8 * U);
        run_model();
        run_scen(0);
        compare_model("sos");
        check("sos_n", rec.size(), 3);
        if (rec.size() >= 3) begin
            check("sos_s1", rec[0].sym, {3'd3, 6'b000000, 1'b0});
            check("sos_o", rec[1].sym, {3'd3, 6'b000111, 1'b0});
            check("sos_s2", rec[2].sym, {3'd3, 6'b000000, 1'b0});
        end
        check("sos_wg", wg_rec.size(), 1);
        check("sos_ovf", overflow, 1'b0);

        // Glitch inside the inter-element space
        pat.delete();
        add_run(1'b1, U); add_run(1'b0, 1); add_run(1'b1, 2); add_run(1'b0, 1); add_run(1'b1, U);
        add_run(1'b0, 8 * U);
        run_model();
        run_scen(0);
        compare_model("glitch");
        check("glitch_n", rec.size(), 1);
        if (rec.size() >= 1) check("glitch_sym", rec[0].sym, {3'd2, 6'b000000, 1'b0});

        // Seven dots then E
        pat.delete();
        add_bits("10101010101010");
        add_bits("00");
        add_bits("1000");
        add_run(1'b0, 8 * U);
        run_model();
        run_scen(0);
        compare_model("long");
        check("long_n", rec.size(), 2);
        if (rec.size() >= 2) begin
            check("long_c0", rec[0].sym, {3'd6, 6'b000000, 1'b1});
            check("long_c1", rec[1].sym, {3'd1, 6'b000000, 1'b0});
        end

        // Backpressure: E held, T dropped
        pat.delete();
        add_bits("1000");
        add_bits("111000");
        add_run(1'b0, 8 * U);
        run_model();
        run_scen(1 << 30);
        check("bp_nacc", rec.size(), 0);
        check("bp_valid", sym_valid, 1'b1);
        check("bp_held", {sym_len, sym_bits, sym_err}, {3'd1, 6'b000000, 1'b0});
        check("bp_ovf", overflow, 1'b1);
        bad = 0;
        if (m_em.size() >= 1) begin
            for (int k = m_em[0].cyc; k < vhist.size(); k++)
                if (!vhist[k] || phist[k] !== {3'd1, 6'b000000, 1'b0}) bad++;
        end else begin
            bad = 1;
        end
        check("bp_stable", bad, 0);
        @(negedge CLK);
        sym_ready = 1'b1;
        @(negedge CLK);
        sym_ready = 1'b0;
        check("bp_drain", sym_valid, 1'b0);
        check("bp_ovf_sticky", overflow, 1'b1);

        // Accept in the exact cycle the second character loads
        pat.delete();
        add_bits("1000");
        add_bits("101000");
        add_run(1'b0, 8 * U);
        run_model();
        rf = (m_em.size() >= 2) ? m_em[1].cyc - 1 : 0;
        run_scen(rf);
        check("same_n", rec.size(), 2);
        if (rec.size() >= 2) begin
            check("same_c0_cyc", rec[0].cyc, rf);
            check("same_c0", rec[0].sym, {3'd1, 6'b000000, 1'b0});
            check("same_c1_cyc", rec[1].cyc, rf + 1);
            check("same_c1", rec[1].sym, {3'd2, 6'b000000, 1'b0});
        end
        bad = 0;
        if (m_em.size() >= 2) begin
            for (int k = m_em[0].cyc; k <= m_em[1].cyc; k++) if (!vhist[k]) bad++;
        end else begin
            bad = 1;
        end
        check("same_cont", bad, 0);
        check("same_ovf", overflow, 1'b0);

        // Reset during a dash of O, then S
        do_reset();
        pat.delete();
        add_bits("1000");
        add_bits("1110111");
        for (int k = 0; k < pat.size(); k++) begin
            @(negedge CLK);
            PIN_RX = pat[k];
        end
        @(negedge CLK);
        #2;
        check("mm_held", {sym_valid, sym_len, sym_bits, sym_err}, {1'b1, 3'd1, 6'b000000, 1'b0});
        RST_N = 1'b0;
        #1;
        check("mm_async", {sym_valid, sym_len, sym_bits, sym_err, word_gap, overflow}, 32'd0);
        pat.delete();
        add_bits("10101000");
        add_run(1'b0, 8 * U);
        run_model();
        run_scen(0);
        compare_model("mm");
        check("mm_n", rec.size(), 1);
        if (rec.size() >= 1) check("mm_s", rec[0].sym, {3'd3, 6'b000000, 1'b0});

        // Randomized character streams
        for (int r = 0; r < 3; r++) begin
            gen_random();
            run_model();
            run_scen(0);
            compare_model("rnd");
            check("rnd_ovf", overflow, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
